// File: rtl/clock_divider_sequencer.sv
// Even-integer clock divider with glitch-free start/stop and divisor changes.
// Divisor changes and stops take effect only at a period boundary (clock low -> would rise).
module clock_divider_sequencer #(
   parameter int par_cnt_width       = 16,
   parameter int par_default_divisor = 1000
) (
   input  logic                     i_clk_mhz,
   input  logic                     i_rst_mhz,
   input  logic                     i_run,
   input  logic [par_cnt_width-1:0] i_cfg_divisor,
   input  logic                     i_cfg_valid,
   output logic                     o_cfg_ready,
   output logic                     o_cfg_done,
   output logic                     o_cfg_error,
   output logic [par_cnt_width-1:0] o_active_divisor,
   output logic                     o_clk_div,
   output logic                     o_ce_rise,
   output logic                     o_ce_fall,
   output logic                     o_rst_div
);

   localparam int CW = par_cnt_width;
   localparam logic [CW-1:0] DEF_DIV = CW'(par_default_divisor);
   localparam logic [CW-1:0] DIV_TWO = 2;
   localparam logic [CW-2:0] CNT_ONE = 1;

   typedef enum logic [1:0] {S_STOPPED, S_RUNNING, S_PENDING} state_t;

   state_t        state_q, state_d;
   logic [CW-2:0] cnt_q, cnt_d;
   logic [CW-1:0] act_q, act_d;
   logic [CW-1:0] pend_q, pend_d;
   logic          clk_q, clk_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;
   logic          rst_q, rst_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [CW-2:0] half_m1;
   logic          tgl;
   logic          cfg_fire;
   logic          cfg_bad;

   assign half_m1  = act_q[CW-1:1] - CNT_ONE;
   assign tgl      = (cnt_q == half_m1);
   assign cfg_fire = i_cfg_valid && (state_q != S_PENDING);
   assign cfg_bad  = i_cfg_divisor[0] || (i_cfg_divisor < DIV_TWO);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      pend_d  = pend_q;
      clk_d   = clk_q;
      rst_d   = rst_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = cfg_fire && cfg_bad;

      case (state_q)
         S_STOPPED: begin
            clk_d = 1'b0;
            cnt_d = '0;
            if (cfg_fire && !cfg_bad) begin
               act_d  = i_cfg_divisor;
               done_d = 1'b1;
            end
            if (i_run) state_d = S_RUNNING;
         end
         S_RUNNING, S_PENDING: begin
            if (!tgl) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = '0;
               if (clk_q) begin
                  clk_d  = 1'b0;
                  fall_d = 1'b1;
                  rst_d  = 1'b0;
               end else begin
                  // Period boundary: the only place a new divisor or a stop may land.
                  if (state_q == S_PENDING) begin
                     act_d  = pend_q;
                     done_d = 1'b1;
                  end
                  if (i_run) begin
                     clk_d   = 1'b1;
                     rise_d  = 1'b1;
                     state_d = S_RUNNING;
                  end else begin
                     rst_d   = 1'b1;
                     state_d = S_STOPPED;
                  end
               end
            end
            if (state_q == S_RUNNING && cfg_fire && !cfg_bad) begin
               // A request landing on the stopping boundary is applied directly.
               if (state_d == S_STOPPED) begin
                  act_d  = i_cfg_divisor;
                  done_d = 1'b1;
               end else begin
                  pend_d  = i_cfg_divisor;
                  state_d = S_PENDING;
               end
            end
         end
         default: state_d = S_STOPPED;
      endcase
   end

   always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
      if (i_rst_mhz) begin
         state_q <= S_STOPPED;
         cnt_q   <= '0;
         act_q   <= DEF_DIV;
         pend_q  <= '0;
         clk_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         rst_q   <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         rst_q   <= rst_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign o_cfg_ready      = (state_q != S_PENDING);
   assign o_cfg_done       = done_q;
   assign o_cfg_error      = err_q;
   assign o_active_divisor = act_q;
   assign o_clk_div        = clk_q;
   assign o_ce_rise        = rise_q;
   assign o_ce_fall        = fall_q;
   assign o_rst_div        = rst_q;

endmodule

// File: tb/tb_clock_divider_sequencer.sv
// Bench for clock_divider_sequencer: per-cycle expected {clk,rise,fall,rst} queued, popped each edge.
module tb_clock_divider_sequencer;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          run;
   logic          cv;
   logic [CW-1:0] cdiv;
   logic          ready, done, err;
   logic [CW-1:0] act;
   logic          cdiv_o, rise, fall, rdiv;

   clock_divider_sequencer #(.par_cnt_width(CW), .par_default_divisor(8)) dut (
      .i_clk_mhz(clk), .i_rst_mhz(rst), .i_run(run),
      .i_cfg_divisor(cdiv), .i_cfg_valid(cv),
      .o_cfg_ready(ready), .o_cfg_done(done), .o_cfg_error(err),
      .o_active_divisor(act), .o_clk_div(cdiv_o), .o_ce_rise(rise),
      .o_ce_fall(fall), .o_rst_div(rdiv)
   );

   always #5 clk = ~clk;

   wire [3:0] obs = {cdiv_o, rise, fall, rdiv};

   int checks = 0;
   int failures = 0;
   logic [3:0] sbq[$];
   logic [3:0] e;

   // Ideal waveform k cycles after the start edge for half-period h.
   function automatic logic [3:0] wave(int k, int h, int rst_until);
      int p;
      logic c, ed;
      p  = k / h;
      c  = p[0];
      ed = (k % h) == 0;
      return {c, ed && c, ed && !c && (p > 0), k < rst_until};
   endfunction

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; cv = 1'b0; cdiv = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; cv = 1'b0; cdiv = '0;
      #3;
      checks++; if (obs !== 4'b0001) begin failures++; $display("FAIL reset_wave got=%b exp=0001", obs); end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
      checks++; if (act !== 16'd8) begin failures++; $display("FAIL reset_active got=%0d exp=8", act); end
      @(posedge clk); #1; rst = 1'b0;
      sbq.delete();
      for (int k = 0; k < 3; k++) sbq.push_back(4'b0001);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL stopped_hold k=%0d got=%b exp=%b", k, obs, e); end
      end
   endtask

   task automatic test_start();
      do_reset();
      sbq.delete();
      for (int k = 0; k < 24; k++) sbq.push_back(wave(k, 4, 8));
      run = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL start_wave k=%0d got=%b exp=%b", k, obs, e); end
      end
      checks++; if (act !== 16'd8) begin failures++; $display("FAIL start_active got=%0d exp=8", act); end
   endtask

   task automatic test_reconfig();
      do_reset();
      sbq.delete();
      for (int k = 0; k < 28; k++) sbq.push_back(k < 12 ? wave(k, 4, 8) : wave(k - 10, 2, 0));
      run = 1'b1;
      for (int k = 0; k < 28; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL reconfig_wave k=%0d got=%b exp=%b", k, obs, e); end
         if (k == 5) begin cv = 1'b1; cdiv = 16'd4; end
         if (k == 6) begin
            cv = 1'b0;
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reconfig_ready_low got=%b exp=0", ready); end
         end
         if (k == 11) begin
            checks++; if ({ready, done} !== 2'b00) begin failures++; $display("FAIL reconfig_wait got=%b exp=00", {ready, done}); end
            checks++; if (act !== 16'd8) begin failures++; $display("FAIL reconfig_old_active got=%0d exp=8", act); end
         end
         if (k == 12) begin
            checks++; if ({ready, done} !== 2'b11) begin failures++; $display("FAIL reconfig_done got=%b exp=11", {ready, done}); end
            checks++; if (act !== 16'd4) begin failures++; $display("FAIL reconfig_new_active got=%0d exp=4", act); end
         end
         if (k == 13) begin
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL reconfig_done_pulse got=%b exp=0", done); end
         end
      end
   endtask

   task automatic test_cfg_error();
      do_reset();
      cv = 1'b1; cdiv = 16'd7;
      @(posedge clk); #1;
      checks++; if ({err, done, ready} !== 3'b101) begin failures++; $display("FAIL err_odd got=%b exp=101", {err, done, ready}); end
      cdiv = 16'd0;
      @(posedge clk); #1;
      checks++; if ({err, done, ready} !== 3'b101) begin failures++; $display("FAIL err_zero got=%b exp=101", {err, done, ready}); end
      checks++; if (act !== 16'd8) begin failures++; $display("FAIL err_active got=%0d exp=8", act); end
      cv = 1'b0;
      @(posedge clk); #1;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
      sbq.delete();
      for (int k = 0; k < 16; k++) sbq.push_back(wave(k, 4, 8));
      run = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL err_run_wave k=%0d got=%b exp=%b", k, obs, e); end
         if (k == 2) begin cv = 1'b1; cdiv = 16'd3; end
         if (k == 3) begin
            cv = 1'b0;
            checks++; if ({err, ready} !== 2'b11) begin failures++; $display("FAIL err_run got=%b exp=11", {err, ready}); end
            checks++; if (act !== 16'd8) begin failures++; $display("FAIL err_run_active got=%0d exp=8", act); end
         end
      end
   endtask

   task automatic test_stop();
      do_reset();
      sbq.delete();
      for (int k = 0; k < 30; k++)
         sbq.push_back(k < 12 ? wave(k, 4, 8) : (k < 16 ? 4'b0001 : wave(k - 16, 4, 8)));
      run = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL stop_wave k=%0d got=%b exp=%b", k, obs, e); end
         if (k == 5) run = 1'b0;
         if (k == 15) run = 1'b1;
      end
   endtask

   task automatic test_reset_pending();
      do_reset();
      sbq.delete();
      for (int k = 0; k < 8; k++) sbq.push_back(wave(k, 4, 8));
      run = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL pend_wave k=%0d got=%b exp=%b", k, obs, e); end
         if (k == 5) begin cv = 1'b1; cdiv = 16'd4; end
         if (k == 6) begin
            cv = 1'b0;
            checks++; if (ready !== 1'b0) begin failures++; $display("FAIL pend_ready got=%b exp=0", ready); end
         end
      end
      #2; rst = 1'b1; run = 1'b0;
      #1;
      checks++; if (obs !== 4'b0001) begin failures++; $display("FAIL async_rst_wave got=%b exp=0001", obs); end
      checks++; if ({ready, done, err} !== 3'b100) begin failures++; $display("FAIL async_rst_cfg got=%b exp=100", {ready, done, err}); end
      checks++; if (act !== 16'd8) begin failures++; $display("FAIL async_rst_active got=%0d exp=8", act); end
      @(posedge clk); #1; rst = 1'b0;
      sbq.delete();
      for (int k = 0; k < 20; k++) sbq.push_back(wave(k, 4, 8));
      run = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL discard_wave k=%0d got=%b exp=%b", k, obs, e); end
      end
      checks++; if (act !== 16'd8) begin failures++; $display("FAIL discard_active got=%0d exp=8", act); end
   endtask

   task automatic test_div2();
      do_reset();
      cv = 1'b1; cdiv = 16'd2;
      @(posedge clk); #1;
      checks++; if ({done, err} !== 2'b10) begin failures++; $display("FAIL div2_done got=%b exp=10", {done, err}); end
      checks++; if (act !== 16'd2) begin failures++; $display("FAIL div2_active got=%0d exp=2", act); end
      cv = 1'b0;
      sbq.delete();
      for (int k = 0; k < 12; k++) sbq.push_back(wave(k, 1, 2));
      run = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         e = sbq.pop_front();
         checks++; if (obs !== e) begin failures++; $display("FAIL div2_wave k=%0d got=%b exp=%b", k, obs, e); end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_reconfig();
      test_cfg_error();
      test_stop();
      test_reset_pending();
      test_div2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
